// File: rtl/matrix_add_sub_seq.sv
// -----------------------------------------------------------------------------
// matrix_add_sub_seq
//
// Row-sequential signed nos x nos matrix adder/subtractor with saturation.
// It sits downstream of the matrix multiplier and uses the same handshake:
// start with addON, get a one-cycle completion flag on endAdd.
// Res = A + B (subSel = 0) or Res = A - B (subSel = 1).
// One row of nos elements is produced per enabled clock.
//
// Ports
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   clk_en  : clock enable; all state holds while low
//   addON   : start request, sampled only in IDLE
//   subSel  : 0 = add, 1 = subtract; captured at start
//   A, B    : operand matrices, WIDTH-bit two's complement, captured at start
//   Res     : result matrix; rows that are not yet written read zero
//   busy    : high in ROW and DONE
//   endAdd  : high for exactly one enabled cycle, while in DONE
//   ovf     : sticky saturation flag for the current/last operation
//
// State table
//   IDLE | waiting for addON; Res and ovf hold the last result
//   ROW  | writing row rowIdx of Res on each enabled edge
//   DONE | all rows written; endAdd high; returns to IDLE
// -----------------------------------------------------------------------------
module matrix_add_sub_seq #(
    parameter int WIDTH = 16,
    parameter int nos   = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  clk_en,
    input  logic                                  addON,
    input  logic                                  subSel,
    input  logic [nos-1:0][nos-1:0][WIDTH-1:0]    A,
    input  logic [nos-1:0][nos-1:0][WIDTH-1:0]    B,
    output logic [nos-1:0][nos-1:0][WIDTH-1:0]    Res,
    output logic                                  busy,
    output logic                                  endAdd,
    output logic                                  ovf
);

    localparam int RW = $clog2(nos);
    localparam logic [RW-1:0] LAST_ROW = RW'(nos - 1);

    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ROW  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                              r_state;
    logic [RW-1:0]                       r_row;
    logic [nos-1:0][nos-1:0][WIDTH-1:0]  r_a;
    logic [nos-1:0][nos-1:0][WIDTH-1:0]  r_b;
    logic                                r_sub;

    logic [nos-1:0][WIDTH:0]             w_sum;
    logic [nos-1:0][WIDTH-1:0]           w_row;
    logic                                w_row_sat;

    // One row of WIDTH+1-bit add/sub. With both operands sign-extended by one
    // bit the true result always fits, so the two top bits disagree exactly
    // when the WIDTH-bit range is exceeded; the top bit gives the direction.
    always_comb begin
        w_sum     = '0;
        w_row     = '0;
        w_row_sat = 1'b0;
        for (int j = 0; j < nos; j++) begin
            if (r_sub) begin
                w_sum[j] = {r_a[r_row][j][WIDTH-1], r_a[r_row][j]}
                         - {r_b[r_row][j][WIDTH-1], r_b[r_row][j]};
            end else begin
                w_sum[j] = {r_a[r_row][j][WIDTH-1], r_a[r_row][j]}
                         + {r_b[r_row][j][WIDTH-1], r_b[r_row][j]};
            end
            if (w_sum[j][WIDTH] != w_sum[j][WIDTH-1]) begin
                w_row_sat = 1'b1;
                w_row[j]  = w_sum[j][WIDTH] ? SAT_NEG : SAT_POS;
            end else begin
                w_row[j]  = w_sum[j][WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_row   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sub   <= 1'b0;
            Res     <= '0;
            busy    <= 1'b0;
            endAdd  <= 1'b0;
            ovf     <= 1'b0;
        end else if (clk_en) begin
            case (r_state)
                S_IDLE: begin
                    if (addON) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_sub   <= subSel;
                        Res     <= '0;
                        ovf     <= 1'b0;
                        r_row   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_ROW;
                    end
                end
                S_ROW: begin
                    Res[r_row] <= w_row;
                    if (w_row_sat) begin
                        ovf <= 1'b1;
                    end
                    if (r_row == LAST_ROW) begin
                        r_row   <= '0;
                        endAdd  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_row   <= r_row + 1'b1;
                    end
                end
                S_DONE: begin
                    endAdd  <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_row   <= '0;
                    endAdd  <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_add_sub_seq.sv
// -----------------------------------------------------------------------------
// tb_matrix_add_sub_seq
//
// Self-checking bench for matrix_add_sub_seq (WIDTH = 16, nos = 4).
// Expected results come from an integer reference model and are queued when a
// start is driven; they are popped and compared when endAdd is seen.
// -----------------------------------------------------------------------------
module tb_matrix_add_sub_seq;

    localparam int W = 16;
    localparam int N = 4;

    typedef logic [N-1:0][N-1:0][W-1:0] mat_t;

    logic clk;
    logic rst_n;
    logic clk_en;
    logic addON;
    logic subSel;
    mat_t A;
    mat_t B;
    mat_t Res;
    logic busy;
    logic endAdd;
    logic ovf;

    int errors = 0;
    int checks = 0;

    mat_t exp_q[$];
    logic exp_ovf_q[$];

    matrix_add_sub_seq #(.WIDTH(W), .nos(N)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .clk_en (clk_en),
        .addON  (addON),
        .subSel (subSel),
        .A      (A),
        .B      (B),
        .Res    (Res),
        .busy   (busy),
        .endAdd (endAdd),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        chk(tag, {255'b0, got}, {255'b0, exp});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic mat_t model(input mat_t a, input mat_t b, input logic sub,
                                   output logic ov);
        mat_t r;
        int   x;
        int   y;
        int   s;
        ov = 1'b0;
        r  = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                x = int'($signed(a[i][j]));
                y = int'($signed(b[i][j]));
                s = sub ? (x - y) : (x + y);
                if (s > 32767) begin
                    s  = 32767;
                    ov = 1'b1;
                end else if (s < -32768) begin
                    s  = -32768;
                    ov = 1'b1;
                end
                r[i][j] = 16'(s);
            end
        end
        return r;
    endfunction

    function automatic mat_t diag(input int v);
        mat_t r;
        r = '0;
        for (int i = 0; i < N; i++) r[i][i] = 16'(v);
        return r;
    endfunction

    task automatic push_exp(input mat_t a, input mat_t b, input logic sub);
        logic ov;
        mat_t e;
        e = model(a, b, sub, ov);
        exp_q.push_back(e);
        exp_ovf_q.push_back(ov);
    endtask

    // Drives operands with addON for one enabled edge (edge 0 of the run).
    task automatic start_run(input mat_t a, input mat_t b, input logic sub);
        A      = a;
        B      = b;
        subSel = sub;
        push_exp(a, b, sub);
        addON  = 1'b1;
        step();
        addON  = 1'b0;
    endtask

    // Edges 1..N of an ungated run, then the DONE -> IDLE edge.
    task automatic run_check(input string tag);
        mat_t e;
        logic eo;
        for (int k = 1; k <= N; k++) begin
            step();
            if (k < N) chk1({tag, "_end_early"}, endAdd, 1'b0);
        end
        chk1({tag, "_end"}, endAdd, 1'b1);
        chk1({tag, "_busy_done"}, busy, 1'b1);
        e  = 'x;
        eo = 1'bx;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            eo = exp_ovf_q.pop_front();
        end
        chk({tag, "_res"}, Res, e);
        chk1({tag, "_ovf"}, ovf, eo);
        step();
        chk1({tag, "_end_fall"}, endAdd, 1'b0);
        chk1({tag, "_busy_fall"}, busy, 1'b0);
    endtask

    initial begin
        mat_t ma;
        mat_t mb;
        mat_t mx;
        mat_t my;
        mat_t mp;
        logic saw_end;
        int   en_cnt;
        logic just_done;
        int   acc;

        rst_n  = 1'b0;
        clk_en = 1'b1;
        addON  = 1'b0;
        subSel = 1'b0;
        A      = '0;
        B      = '0;

        // Reset state
        step();
        step();
        chk("rst_res", Res, '0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_end", endAdd, 1'b0);
        chk1("rst_ovf", ovf, 1'b0);
        rst_n = 1'b1;
        step();

        // Basic add: I*5 + I*3 = I*8
        start_run(diag(5), diag(3), 1'b0);
        chk1("add_busy_start", busy, 1'b1);
        chk1("add_end_start", endAdd, 1'b0);
        run_check("add");
        chk("add_res_i8", Res, diag(8));

        // Reset mid-operation (asserted before edge 2)
        start_run(diag(5), diag(3), 1'b0);
        step();
        rst_n = 1'b0;
        #1;
        chk("midrst_res", Res, '0);
        chk1("midrst_busy", busy, 1'b0);
        exp_q.delete();
        exp_ovf_q.delete();
        step();
        step();
        rst_n   = 1'b1;
        saw_end = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (endAdd) saw_end = 1'b1;
        end
        chk1("midrst_no_end", saw_end, 1'b0);
        chk1("midrst_idle", busy, 1'b0);

        // Subtraction and sign
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = 16'(i * 4 + j);
                mb[i][j] = 16'h0002;
            end
        start_run(ma, mb, 1'b1);
        run_check("sub");
        chk("sub_r00", {240'b0, Res[0][0]}, {240'b0, 16'hFFFE});
        chk("sub_r33", {240'b0, Res[3][3]}, {240'b0, 16'd13});

        // Positive saturation
        ma = '0;
        mb = '0;
        ma[1][2] = 16'h7FF0;
        mb[1][2] = 16'h0020;
        start_run(ma, mb, 1'b0);
        chk("sat_clear_res", Res, '0);
        run_check("satp");
        chk("satp_r12", {240'b0, Res[1][2]}, {240'b0, 16'h7FFF});
        chk1("satp_ovf", ovf, 1'b1);

        // Negative saturation
        ma = '0;
        mb = '0;
        ma[2][0] = 16'h8000;
        mb[2][0] = 16'h0001;
        start_run(ma, mb, 1'b1);
        run_check("satn");
        chk("satn_r20", {240'b0, Res[2][0]}, {240'b0, 16'h8000});
        step();
        chk1("satn_ovf_sticky", ovf, 1'b1);

        // Clean run clears ovf at its start edge
        start_run(diag(7), diag(-2), 1'b0);
        chk1("clean_ovf_start", ovf, 1'b0);
        run_check("clean");

        // clk_en gating: pattern 0,0,1,1,0,0,1,1...
        start_run(diag(5), diag(3), 1'b0);
        en_cnt = 0;
        for (int c = 0; c < 64 && en_cnt <= N; c++) begin
            clk_en    = ((c >> 1) & 1) == 1;
            just_done = 1'b0;
            step();
            if (clk_en) begin
                en_cnt++;
                if (en_cnt == N) just_done = 1'b1;
            end
            if (en_cnt < N) begin
                chk1("gate_end_early", endAdd, 1'b0);
            end else if (en_cnt == N) begin
                chk1("gate_end_held", endAdd, 1'b1);
                if (just_done) begin
                    mp = 'x;
                    if (exp_q.size() > 0) begin
                        mp = exp_q.pop_front();
                        void'(exp_ovf_q.pop_front());
                    end
                    chk("gate_res", Res, mp);
                end
            end else begin
                chk1("gate_end_fall", endAdd, 1'b0);
                chk1("gate_busy_fall", busy, 1'b0);
            end
        end
        chk("gate_bound", 256'(en_cnt), 256'(N + 1));
        clk_en = 1'b1;
        chk("gate_res_i8", Res, diag(8));

        // Operand capture, ignored start, restart on the edge after IDLE return
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = 16'(i * 100 + j * 7);
                mb[i][j] = 16'(j * 3 - i);
                mx[i][j] = 16'(1000 + i + j);
                my[i][j] = 16'(-(i * j));
            end
        start_run(ma, mb, 1'b0);
        A      = mx;
        B      = my;
        subSel = 1'b1;
        addON  = 1'b1;
        run_check("cap");
        push_exp(mx, my, 1'b1);
        step();
        chk1("restart_busy", busy, 1'b1);
        addON = 1'b0;
        A     = '0;
        B     = '0;
        run_check("restart");

        // Chained with a behavioural multiplier: addON driven by its end flag
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                mx[i][j] = 16'(i - j);
                my[i][j] = 16'(i + j + 1);
            end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                acc = 0;
                for (int k = 0; k < N; k++)
                    acc += int'($signed(mx[i][k])) * int'($signed(my[k][j]));
                mp[i][j] = 16'(acc);
            end
        mb = diag(100);
        mb[0][3] = 16'hFFF6;
        for (int k = 0; k < 3; k++) step();
        A      = mp;
        B      = mb;
        subSel = 1'b0;
        push_exp(mp, mb, 1'b0);
        addON  = 1'b1;
        step();
        addON  = 1'b0;
        A      = '0;
        run_check("chain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
